multicycle_control: RTL and testbench

- Main control FSM for the multicycle MIPS-subset CPU. It sequences the shared datapath (PC, IR, register file, single ALU, unified memory) through fetch/decode/execute/memory/writeback.
- Drives the 2-bit ALUOp consumed by alu_controlUnit, plus every datapath mux select and write enable.
- Stalls on a memory ready handshake.

---
 rtl/cpu_ctrl_pkg.sv | 41 ++++
 rtl/multicycle_control.sv | 158 +++++++++++++++
 tb/tb_multicycle_control.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle CPU control path: FSM states, opcodes,
// ALUOp codes and the datapath mux select values.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_FUNCT = 2'b00;
  localparam logic [1:0] ALUOP_ADD   = 2'b10;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS-subset CPU.
//
//   state  | meaning
//   FETCH  | read instruction at PC, PC <= PC+4 once mem_ready
//   DECODE | ALUOut <= branch target, dispatch on opcode
//   MEMADR | ALUOut <= regA + signext imm (lw/sw address)
//   MEMRD  | read data memory into MDR, wait for mem_ready
//   MEMWB  | rt <= MDR
//   MEMWR  | write regB to memory, wait for mem_ready
//   REXEC  | ALUOut <= regA op regB (funct-controlled)
//   RWB    | rd <= ALUOut
//   BRANCH | compare regA/regB, PC <= ALUOut if taken
//   ADDIEX | ALUOut <= regA + signext imm
//   ADDIWB | rt <= ALUOut
//   JUMP   | PC <= jump target
module multicycle_control
  import cpu_ctrl_pkg::*;
#(
  parameter state_e RESET_STATE = S_FETCH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [1:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       pc_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       illegal_op,
  output logic [3:0] state_o
);

  state_e state_q, state_d;

  // State register, returns to the reset state asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RESET_STATE;
    else     state_q <= state_d;
  end

  // Next-state selection; unknown encodings fall back to FETCH.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_RTYPE:       state_d = S_REXEC;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_ADDI:        state_d = S_ADDIEX;
          OP_J:           state_d = S_JUMP;
          default:        state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_REXEC:  state_d = S_RWB;
      S_RWB:    state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Output decode. Gated by rst so no write strobe survives a reset
  // assertion, even though FETCH itself drives mem_read.
  always_comb begin
    alu_op     = ALUOP_FUNCT;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REGB;
    pc_src     = PCSRC_ALU;
    pc_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    illegal_op = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          alu_op    = ALUOP_ADD;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_b = SRCB_IMM_SH2;
          alu_op    = ALUOP_ADD;
          case (opcode)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDI, OP_J: illegal_op = 1'b0;
            default: illegal_op = 1'b1;
          endcase
        end
        S_MEMADR, S_ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_op    = ALUOP_ADD;
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        S_REXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_REGB;
          alu_op    = ALUOP_FUNCT;
        end
        S_RWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_REGB;
          alu_op    = ALUOP_SUB;
          pc_src    = PCSRC_ALUOUT;
          if (opcode == OP_BEQ)      pc_write = zero;
          else if (opcode == OP_BNE) pc_write = !zero;
        end
        S_ADDIWB: reg_write = 1'b1;
        S_JUMP: begin
          pc_src   = PCSRC_JUMP;
          pc_write = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed-vector bench for the multicycle CPU control FSM.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic [1:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic       pc_write;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       illegal_op;
  logic [3:0] state_o;

  int n_vec  = 0;
  int n_miss = 0;

  localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_MEMADR = 4'd2,
                         ST_MEMRD = 4'd3, ST_MEMWB = 4'd4, ST_MEMWR = 4'd5,
                         ST_REXEC = 4'd6, ST_RWB = 4'd7, ST_BRANCH = 4'd8,
                         ST_ADDIEX = 4'd9, ST_ADDIWB = 4'd10, ST_JUMP = 4'd11;

  multicycle_control dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .alu_op     (alu_op),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_src     (pc_src),
    .pc_write   (pc_write),
    .iord       (iord),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .illegal_op (illegal_op),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  logic [16:0] outs;
  assign outs = {alu_op, alu_src_a, alu_src_b, pc_src, pc_write, iord, mem_read,
                 mem_write, ir_write, reg_dst, mem_to_reg, reg_write, illegal_op};

  function automatic logic [16:0] mk(logic [1:0] aop, logic sa, logic [1:0] sb,
                                     logic [1:0] ps, logic pw, logic io, logic mr,
                                     logic mw, logic irw, logic rd, logic m2r,
                                     logic rw, logic ill);
    return {aop, sa, sb, ps, pw, io, mr, mw, irw, rd, m2r, rw, ill};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check state and outputs.
  task automatic cyc(input string tag, input logic [5:0] op, input logic z,
                     input logic mr, input logic [3:0] es, input logic [16:0] eo);
    @(negedge clk);
    opcode = op; zero = z; mem_ready = mr;
    #1;
    chk({tag, ".state"}, {28'd0, state_o}, {28'd0, es});
    chk({tag, ".outs"}, {15'd0, outs}, {15'd0, eo});
  endtask

  logic [16:0] O_ZERO, O_FETCH_GO, O_FETCH_WAIT, O_DEC, O_DEC_ILL, O_MEMADR,
               O_MEMRD, O_MEMWB, O_MEMWR, O_REXEC, O_RWB, O_BR_T, O_BR_N,
               O_ADDIWB, O_JUMP;

  initial begin
    O_ZERO       = 17'd0;
    O_FETCH_GO   = mk(2'b10,0,2'b01,2'b00,1,0,1,0,1,0,0,0,0);
    O_FETCH_WAIT = mk(2'b10,0,2'b01,2'b00,0,0,1,0,0,0,0,0,0);
    O_DEC        = mk(2'b10,0,2'b11,2'b00,0,0,0,0,0,0,0,0,0);
    O_DEC_ILL    = mk(2'b10,0,2'b11,2'b00,0,0,0,0,0,0,0,0,1);
    O_MEMADR     = mk(2'b10,1,2'b10,2'b00,0,0,0,0,0,0,0,0,0);
    O_MEMRD      = mk(2'b00,0,2'b00,2'b00,0,1,1,0,0,0,0,0,0);
    O_MEMWB      = mk(2'b00,0,2'b00,2'b00,0,0,0,0,0,0,1,1,0);
    O_MEMWR      = mk(2'b00,0,2'b00,2'b00,0,1,0,1,0,0,0,0,0);
    O_REXEC      = mk(2'b00,1,2'b00,2'b00,0,0,0,0,0,0,0,0,0);
    O_RWB        = mk(2'b00,0,2'b00,2'b00,0,0,0,0,0,1,0,1,0);
    O_BR_T       = mk(2'b01,1,2'b00,2'b01,1,0,0,0,0,0,0,0,0);
    O_BR_N       = mk(2'b01,1,2'b00,2'b01,0,0,0,0,0,0,0,0,0);
    O_ADDIWB     = mk(2'b00,0,2'b00,2'b00,0,0,0,0,0,0,0,1,0);
    O_JUMP       = mk(2'b00,0,2'b00,2'b10,1,0,0,0,0,0,0,0,0);

    rst = 1'b1; opcode = 6'd0; zero = 1'b0; mem_ready = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    chk("reset.state", {28'd0, state_o}, {28'd0, ST_FETCH});
    chk("reset.outs", {15'd0, outs}, {15'd0, O_ZERO});
    rst = 1'b0;

    // lw, no wait states: 5 cycles
    cyc("lw.fetch",  6'b100011, 0, 1, ST_FETCH,  O_FETCH_GO);
    cyc("lw.decode", 6'b100011, 0, 1, ST_DECODE, O_DEC);
    cyc("lw.memadr", 6'b100011, 0, 1, ST_MEMADR, O_MEMADR);
    cyc("lw.memrd",  6'b100011, 0, 1, ST_MEMRD,  O_MEMRD);
    cyc("lw.memwb",  6'b100011, 0, 1, ST_MEMWB,  O_MEMWB);

    // R-type with two fetch wait cycles
    cyc("r.fetch0", 6'b000000, 0, 0, ST_FETCH,  O_FETCH_WAIT);
    cyc("r.fetch1", 6'b000000, 0, 0, ST_FETCH,  O_FETCH_WAIT);
    cyc("r.fetch2", 6'b000000, 0, 1, ST_FETCH,  O_FETCH_GO);
    cyc("r.decode", 6'b000000, 0, 1, ST_DECODE, O_DEC);
    cyc("r.rexec",  6'b000000, 0, 1, ST_REXEC,  O_REXEC);
    cyc("r.rwb",    6'b000000, 0, 1, ST_RWB,    O_RWB);

    // beq taken
    cyc("beq.fetch",  6'b000100, 1, 1, ST_FETCH,  O_FETCH_GO);
    cyc("beq.decode", 6'b000100, 1, 1, ST_DECODE, O_DEC);
    cyc("beq.branch", 6'b000100, 1, 1, ST_BRANCH, O_BR_T);

    // bne with zero=1: not taken
    cyc("bne.fetch",  6'b000101, 1, 1, ST_FETCH,  O_FETCH_GO);
    cyc("bne.decode", 6'b000101, 1, 1, ST_DECODE, O_DEC);
    cyc("bne.branch", 6'b000101, 1, 1, ST_BRANCH, O_BR_N);

    // bne with zero=0: taken
    cyc("bne0.fetch",  6'b000101, 0, 1, ST_FETCH,  O_FETCH_GO);
    cyc("bne0.decode", 6'b000101, 0, 1, ST_DECODE, O_DEC);
    cyc("bne0.branch", 6'b000101, 0, 1, ST_BRANCH, O_BR_T);

    // sw with three wait cycles in MEMWR
    cyc("sw.fetch",  6'b101011, 0, 1, ST_FETCH,  O_FETCH_GO);
    cyc("sw.decode", 6'b101011, 0, 1, ST_DECODE, O_DEC);
    cyc("sw.memadr", 6'b101011, 0, 1, ST_MEMADR, O_MEMADR);
    cyc("sw.memwr0", 6'b101011, 0, 0, ST_MEMWR,  O_MEMWR);
    cyc("sw.memwr1", 6'b101011, 0, 0, ST_MEMWR,  O_MEMWR);
    cyc("sw.memwr2", 6'b101011, 0, 0, ST_MEMWR,  O_MEMWR);
    cyc("sw.memwr3", 6'b101011, 0, 1, ST_MEMWR,  O_MEMWR);

    // addi
    cyc("addi.fetch",  6'b001000, 0, 1, ST_FETCH,  O_FETCH_GO);
    cyc("addi.decode", 6'b001000, 0, 1, ST_DECODE, O_DEC);
    cyc("addi.ex",     6'b001000, 0, 1, ST_ADDIEX, O_MEMADR);
    cyc("addi.wb",     6'b001000, 0, 1, ST_ADDIWB, O_ADDIWB);

    // j
    cyc("j.fetch",  6'b000010, 0, 1, ST_FETCH,  O_FETCH_GO);
    cyc("j.decode", 6'b000010, 0, 1, ST_DECODE, O_DEC);
    cyc("j.jump",   6'b000010, 0, 1, ST_JUMP,   O_JUMP);

    // illegal opcode: single-cycle pulse, back to FETCH
    cyc("ill.fetch",  6'b111111, 0, 1, ST_FETCH,  O_FETCH_GO);
    cyc("ill.decode", 6'b111111, 0, 1, ST_DECODE, O_DEC_ILL);
    cyc("ill.after",  6'b111111, 0, 0, ST_FETCH,  O_FETCH_WAIT);

    // reset asserted mid-MEMRD
    cyc("rlw.fetch",  6'b100011, 0, 1, ST_FETCH,  O_FETCH_GO);
    cyc("rlw.decode", 6'b100011, 0, 1, ST_DECODE, O_DEC);
    cyc("rlw.memadr", 6'b100011, 0, 1, ST_MEMADR, O_MEMADR);
    cyc("rlw.memrd",  6'b100011, 0, 0, ST_MEMRD,  O_MEMRD);
    #1; rst = 1'b1; #1;
    chk("rstmid.state", {28'd0, state_o}, {28'd0, ST_FETCH});
    chk("rstmid.outs", {15'd0, outs}, {15'd0, O_ZERO});
    mem_ready = 1'b1;
    @(negedge clk); #1;
    chk("rsthold.state", {28'd0, state_o}, {28'd0, ST_FETCH});
    chk("rsthold.outs", {15'd0, outs}, {15'd0, O_ZERO});
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel.state", {28'd0, state_o}, {28'd0, ST_FETCH});
    chk("rel.outs", {15'd0, outs}, {15'd0, O_FETCH_GO});
    cyc("rel.decode", 6'b100011, 0, 1, ST_DECODE, O_DEC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
